// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file: register geometry and the
// architectural register-index type.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle of the multi-port register file: read ports, write ports,
// issue strobe, flush and the scoreboard view.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2
);
   localparam int AW = $clog2(NREGS);

   // No handshake: every strobe (we, iss_valid, flush) is a one-cycle
   // qualifier sampled at the rising edge, and the file always accepts it.
   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      we;
   logic [NWR*AW-1:0]   wa;
   logic [NWR*XLEN-1:0] wd;
   logic [NWR-1:0]      wclr;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic [NREGS-1:0]    busy_vec;
   logic                flush;

   modport master (
      output ra, we, wa, wd, wclr, iss_valid, iss_rd, flush,
      input  rd, rd_busy, busy_vec
   );

   modport slave (
      input  ra, we, wa, wd, wclr, iss_valid, iss_rd, flush,
      output rd, rd_busy, busy_vec
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared
// by a writeback carrying wclr, wiped by flush.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] wa,
   input  logic [NWR-1:0]    wclr,
   input  logic              flush,
   output logic [NREGS-1:0]  busy
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [NREGS-1:0] set_v;
   logic [NREGS-1:0] clr_v;
   logic [NREGS-1:0] busy_nxt;

   always_comb begin
      set_v    = '0;
      clr_v    = '0;
      busy_nxt = busy;
      for (int r = 0; r < NREGS; r++) begin
         set_v[r] = iss_valid && (iss_rd == AW'(r));
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && wclr[j] && (wa[j*AW +: AW] == AW'(r))) clr_v[r] = 1'b1;
         end
      end
      if (flush) begin
         busy_nxt = '0;
      end else begin
         // A new producer supersedes the one retiring in the same cycle.
         for (int r = 0; r < NREGS; r++) begin
            if (set_v[r])      busy_nxt[r] = 1'b1;
            else if (clr_v[r]) busy_nxt[r] = 1'b0;
         end
      end
      if (ZR) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass and
// an integrated pending-write scoreboard for RAW stalls.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave bus
);

   localparam int AW = $clog2(NREGS);
   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);

   logic [XLEN-1:0]  rf [NREGS];
   logic [NREGS-1:0] busy_vec;

   // Later ports overwrite earlier ones in the loop, so the highest index wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) rf[r] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.we[j] && !(ZR && (bus.wa[j*AW +: AW] == '0)))
               rf[bus.wa[j*AW +: AW]] <= bus.wd[j*XLEN +: XLEN];
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] v;

      assign a = bus.ra[i*AW +: AW];

      // Bypass is gated by rst_n so the read data stays zero throughout reset.
      always_comb begin
         v = rf[a];
         if (BP && rst_n) begin
            for (int j = 0; j < NWR; j++) begin
               if (bus.we[j] && (bus.wa[j*AW +: AW] == a)) v = bus.wd[j*XLEN +: XLEN];
            end
         end
         if (ZR && (a == '0)) v = '0;
      end

      assign bus.rd[i*XLEN +: XLEN] = v;
      assign bus.rd_busy[i]         = busy_vec[a];
   end

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .we        (bus.we),
      .wa        (bus.wa),
      .wclr      (bus.wclr),
      .flush     (bus.flush),
      .busy      (busy_vec)
   );

   assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// driven in lockstep from a vector table, plus reset sequences.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int XLEN = 32;
   localparam int NREGS = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2)) bus ();
   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2)) bus_nb ();

   assign bus_nb.ra        = bus.ra;
   assign bus_nb.we        = bus.we;
   assign bus_nb.wa        = bus.wa;
   assign bus_nb.wd        = bus.wd;
   assign bus_nb.wclr      = bus.wclr;
   assign bus_nb.iss_valid = bus.iss_valid;
   assign bus_nb.iss_rd    = bus.iss_rd;
   assign bus_nb.flush     = bus.flush;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0))
      dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]  we;
      reg_addr_t   wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [1:0]  wclr;
      logic        iss_valid;
      reg_addr_t   iss_rd;
      logic        flush;
      reg_addr_t   ra0, ra1;
      logic [31:0] exp_rd0, exp_rd1, exp_nb0, exp_busy;
      logic [1:0]  exp_rdb;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.we = '0; bus.wa = '0; bus.wd = '0; bus.wclr = '0;
      bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0; bus.ra = '0;
   endtask

   task automatic drive_vec(input vec_t v);
      bus.we = v.we; bus.wa = {v.wa1, v.wa0}; bus.wd = {v.wd1, v.wd0};
      bus.wclr = v.wclr; bus.iss_valid = v.iss_valid; bus.iss_rd = v.iss_rd;
      bus.flush = v.flush; bus.ra = {v.ra1, v.ra0};
   endtask

   task automatic add(input logic [1:0] we, input reg_addr_t wa0, input logic [31:0] wd0,
                      input reg_addr_t wa1, input logic [31:0] wd1, input logic [1:0] wclr,
                      input logic iv, input reg_addr_t ird, input logic fl,
                      input reg_addr_t ra0, input reg_addr_t ra1,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] enb,
                      input logic [31:0] eb, input logic [1:0] erb);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.wclr = wclr;
      v.iss_valid = iv; v.iss_rd = ird; v.flush = fl; v.ra0 = ra0; v.ra1 = ra1;
      v.exp_rd0 = e0; v.exp_rd1 = e1; v.exp_nb0 = enb; v.exp_busy = eb; v.exp_rdb = erb;
      vecs.push_back(v);
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act);
      logic [31:0] exp;
      exp = exp_q.pop_front();
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
      exp_q.push_back(exp);
      check(name, act);
   endtask

   // ---------------- test ----------------
   initial begin
      //    we     wa0 wd0           wa1 wd1          wclr   iv ird fl ra0 ra1 rd0           rd1           nb0           busy          rdb
      add(2'b01, 7, 32'h12345678, 0, 32'h0,        2'b00, 0, 0, 0, 7, 0, 32'h12345678, 32'h0,        32'h0,        32'h0,        2'b00);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0,        2'b00);
      add(2'b11, 3, 32'h1,        3, 32'h2,        2'b00, 0, 0, 0, 3, 7, 32'h2,        32'h12345678, 32'h0,        32'h0,        2'b00);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 3, 7, 32'h2,        32'h12345678, 32'h2,        32'h0,        2'b00);
      add(2'b01, 0, 32'hFFFFFFFF, 0, 32'h0,        2'b00, 1, 0, 0, 0, 7, 32'h0,        32'h12345678, 32'h0,        32'h0,        2'b00);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 1, 9, 0, 9, 3, 32'h0,        32'h2,        32'h0,        32'h0,        2'b00);
      add(2'b01, 9, 32'hAAAA5555, 0, 32'h0,        2'b01, 1, 9, 0, 9, 3, 32'hAAAA5555, 32'h2,        32'h0,        32'h200,      2'b01);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 9, 3, 32'hAAAA5555, 32'h2,        32'hAAAA5555, 32'h200,      2'b01);
      add(2'b01, 9, 32'hBBBB0000, 0, 32'h0,        2'b01, 0, 0, 0, 9, 3, 32'hBBBB0000, 32'h2,        32'hAAAA5555, 32'h200,      2'b01);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 9, 3, 32'hBBBB0000, 32'h2,        32'hBBBB0000, 32'h0,        2'b00);
      add(2'b10, 0, 32'h0,        4, 32'h44,       2'b00, 1, 4, 0, 4, 9, 32'h44,       32'hBBBB0000, 32'h0,        32'h0,        2'b00);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 1, 5, 0, 4, 9, 32'h44,       32'hBBBB0000, 32'h44,       32'h10,       2'b01);
      add(2'b01, 6, 32'h66,       0, 32'h0,        2'b00, 1, 6, 1, 5, 6, 32'h0,        32'h66,       32'h0,        32'h30,       2'b01);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 4, 6, 32'h44,       32'h66,       32'h44,       32'h0,        2'b00);
      add(2'b01, 2, 32'h22,       0, 32'h0,        2'b01, 0, 0, 0, 2, 6, 32'h22,       32'h66,       32'h0,        32'h0,        2'b00);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 1, 8, 0, 8, 6, 32'h0,        32'h66,       32'h0,        32'h0,        2'b00);
      add(2'b01, 8, 32'h80,       0, 32'h0,        2'b00, 0, 0, 0, 8, 6, 32'h80,       32'h66,       32'h0,        32'h100,      2'b01);
      add(2'b10, 0, 32'h0,        8, 32'h88,       2'b10, 0, 0, 0, 8, 6, 32'h88,       32'h66,       32'h80,       32'h100,      2'b01);
      add(2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 0, 8, 6, 32'h88,       32'h66,       32'h88,       32'h0,        2'b00);

      // Reset state
      drive_idle();
      rst_n = 1'b0;
      #2;
      check_now("reset_rd", bus.rd[31:0], 32'h0);
      check_now("reset_busy", bus.busy_vec, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < vecs.size(); k++) begin
         drive_vec(vecs[k]);
         #1;
         exp_q.push_back(vecs[k].exp_rd0);
         exp_q.push_back(vecs[k].exp_rd1);
         exp_q.push_back(vecs[k].exp_nb0);
         exp_q.push_back(vecs[k].exp_busy);
         exp_q.push_back({30'h0, vecs[k].exp_rdb});
         check($sformatf("v%0d_rd0", k), bus.rd[31:0]);
         check($sformatf("v%0d_rd1", k), bus.rd[63:32]);
         check($sformatf("v%0d_nb_rd0", k), bus_nb.rd[31:0]);
         check($sformatf("v%0d_busy_vec", k), bus.busy_vec);
         check($sformatf("v%0d_rd_busy", k), {30'h0, bus.rd_busy});
         @(posedge clk); #1;
      end

      // Mid-run asynchronous reset with x5 holding data and busy
      drive_idle();
      bus.we = 2'b01; bus.wa = {5'd0, 5'd5}; bus.wd = {32'h0, 32'hDEADBEEF};
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.ra = {5'd0, 5'd5};
      @(posedge clk); #1;
      drive_idle();
      bus.ra = {5'd0, 5'd5};
      #1;
      check_now("pre_reset_rd", bus.rd[31:0], 32'hDEADBEEF);
      check_now("pre_reset_busy", bus.busy_vec, 32'h20);
      rst_n = 1'b0;
      #1;
      check_now("async_reset_rd", bus.rd[31:0], 32'h0);
      check_now("async_reset_nb_rd", bus_nb.rd[31:0], 32'h0);
      check_now("async_reset_busy", bus.busy_vec, 32'h0);
      check_now("async_reset_rd_busy", {30'h0, bus.rd_busy}, 32'h0);

      // Writes and issues in the release cycle are honoured
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.we = 2'b01; bus.wa = {5'd0, 5'd5}; bus.wd = {32'h0, 32'h00005555};
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
      @(posedge clk); #1;
      drive_idle();
      bus.ra = {5'd10, 5'd5};
      #1;
      check_now("release_rd", bus.rd[31:0], 32'h00005555);
      check_now("release_nb_rd", bus_nb.rd[31:0], 32'h00005555);
      check_now("release_busy", bus.busy_vec, 32'h400);
      check_now("release_rd_busy", {30'h0, bus.rd_busy}, 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard.
- Intended for pipelined and dual-issue cores in this design.
- Writes commit on the rising clock edge. A combinational write-to-read bypass lets a value written in a cycle be seen by reads in that same cycle.
- The per-register busy bits let decode stall on outstanding writes (RAW hazards).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy.
- BYPASS, 1, when 1, reads forward same-cycle write data; when 0, reads return the stored value only.
- AW (localparam), $clog2(NREGS), address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  read addresses; port i uses slice [i*AW +: AW].
- rd  out  NRD*XLEN  read data; port i uses slice [i*XLEN +: XLEN].
- rd_busy  out  NRD  busy bit of the register addressed by ra for port i.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- wclr  in  NWR  when 1 with we, the write also clears the busy bit of wa.
- iss_valid  in  1  issue strobe: marks iss_rd as having a pending write.
- iss_rd  in  AW  destination register being issued.
- busy_vec  out  NREGS  full scoreboard, for debug and flush logic.
- flush  in  1  synchronous clear of all busy bits; data is kept.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers go to 0 and all busy bits go to 0.
  - Outputs are therefore rd=0, rd_busy=0 and busy_vec=0 whenever reset is asserted.
  - Reset deassertion takes effect at the next rising edge; writes and issues in that cycle are honoured.
- Write: on posedge, for each port j with we[j]=1, rf[wa[j]] <= wd[j].
  - If several ports hit the same address, the highest-index port wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, 0-cycle latency):
  - ZERO_REG=1 and ra=0 gives 0.
  - Otherwise, with BYPASS=1, the highest-index port j with we[j] and wa[j]==ra supplies wd[j].
  - Otherwise rd = rf[ra].
- Scoreboard next state, per register r:
  - flush=1: all busy bits go to 0. A same-cycle issue is ignored; data writes still commit.
  - Otherwise set = iss_valid && iss_rd==r, and clr = any j with we[j] && wclr[j] && wa[j]==r.
  - If set, busy[r] <= 1. Set beats clr, because a new producer supersedes the retiring one.
  - Else if clr, busy[r] <= 0.
  - Else busy[r] holds.
  - busy[0] is tied to 0 when ZERO_REG=1.
- rd_busy[i] = busy_vec[ra[i]], the registered value with no bypass of same-cycle set or clr.
  - Decode therefore sees a clear one cycle after writeback. This is the documented stall-by-one-cycle behaviour.
- A write with wclr=0 updates data only. A clr on a register that is not busy has no effect.
- Index arithmetic is purely AW-bit; there are no out-of-range addresses.

Decomposition:
- Package regfile_pkg: default XLEN, NREGS and derived AW, and a reg_addr_t typedef.
- Sub-module rf_scoreboard: busy bits with set, clr and flush; instantiated once.
- Storage, write priority and the bypass muxes stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-run after writing x5=0xDEADBEEF -> rd for ra=5 is 0 immediately (asynchronous) and busy_vec=0.
- Bypass and commit: we[0]=1, wa=7, wd=0x12345678, ra[0]=7 in the same cycle.
  - BYPASS=1: rd=0x12345678 combinationally in that cycle, and the next cycle reads the stored value.
  - BYPASS=0: that cycle reads the old value.
- Write conflict: we=2'b11, wa[0]=wa[1]=3, wd=0x1 and 0x2 -> after the edge x3=0x2, and the same-cycle bypassed read is 0x2.
- Zero register: write 0xFFFF_FFFF to x0 with iss_valid, iss_rd=0 -> rd=0 and busy_vec[0]=0.
- Scoreboard lifecycle:
  - Issue x9 -> busy_vec[9]=1 next cycle.
  - Writeback with wclr=1 and a simultaneous issue of x9 -> busy stays 1.
  - A later writeback with wclr and no issue -> busy 0 one cycle later.
  - flush -> all busy bits 0 and data unchanged.
